decade_run_ctrl: RTL
====================

Name: decade_run_ctrl

Overview:
Run/stop sequencer for a cascade of decade (BCD 0-9) counters. It generates the count-enable ticks from a programmable prescaler and accepts start/stop/clear pulses through a small FSM. Carries ripple through DIGITS decade cells. An optional terminal-count compare halts the run. It sits between the user control logic and the digit display/readout path.

Parameters:
DIGITS, 4, number of cascaded decade digits (>=1)
TICK_DIV, 10, clk cycles per count increment while running (>=1)
PRE_W, $clog2(TICK_DIV)>0 ? $clog2(TICK_DIV) : 1, prescaler width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  start/resume command pulse
stop  in  1  pause command pulse
clear  in  1  synchronous clear command pulse
target_en  in  1  enable terminal-count compare
target  in  4*DIGITS  terminal count, BCD packed, digit0 in [3:0]
count  out  4*DIGITS  current BCD count, digit0 in [3:0]
running  out  1  high while state==RUN
done  out  1  terminal count reached, level until clear/reset
tick  out  1  one-cycle pulse on each count increment
wrap  out  1  one-cycle pulse when count rolls all-9s -> all-0s

Behaviour:
- reset low (async): state=IDLE, count=0, prescaler=0, running=0, done=0, tick=0, wrap=0. Release is synchronous to clk.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN), decoded from the state register.
- Commands are sampled on each rising edge. Priority is clear > stop > start. A lower-priority command asserted with a higher one is ignored that cycle.
- clear, from any state: state->IDLE, count=0, prescaler=0, done=0.
- start: IDLE->RUN and PAUSE->RUN. Ignored in RUN and DONE, where DONE requires clear.
- stop: RUN->PAUSE. Prescaler and count are held, not reset, so a resume keeps the phase. Ignored in other states.
- Prescaler advances only on edges where the state register is already RUN. The edge that samples start does not advance it.
- In RUN: if prescaler==TICK_DIV-1, prescaler<=0 and the count increments. Otherwise prescaler<=prescaler+1. With TICK_DIV=1 the count increments on every RUN edge.
- Increment rule: digit0+1. Any digit at 9 that receives a carry becomes 0 and passes the carry on. Digits never hold values >9.
- All digits at 9 plus an increment: count=0, wrap=1 for that cycle only.
- tick and wrap are registered. They assert in the cycle after the increment edge, together with the new count, and are 0 at all other times, including PAUSE, IDLE and DONE.
- Terminal compare: if target_en=1 and the next count value equals target, then on that same edge count<=target, state->DONE, done<=1, and tick asserts.
  - target=0 matches on wrap, so wrap and done assert together.
  - target is sampled live. A target digit >9 never matches.
  - Changing target while in RUN does not retroactively match the current count; only increments are compared.
- In DONE: count, prescaler and done are held, and start and stop are ignored.
- Latency: from a start in IDLE, the first increment is on the TICK_DIV-th edge after the start-sampling edge.

Decomposition:
- Package decade_pkg:
  - typedef enum {IDLE, RUN, PAUSE, DONE} run_state_t
  - typedef logic [3:0] bcd_t
  - localparam BCD_MAX=4'd9
- Sub-module decade_cell: one digit.
  - Inputs: clk, reset, clr, inc, load_en/load_val (unused by default, tie 0).
  - Outputs: q [3:0], carry_out = inc & (q==9).
- decade_run_ctrl contains the FSM and prescaler, and instantiates DIGITS decade_cell in a generate chain.

Test Plan:
All scenarios use DIGITS=2, TICK_DIV=4.
1. Pulse reset low while in RUN with count=0x37 -> count=0x00, running=0, done=0, tick=0 immediately (async), and they stay 0 after release with no start.
2. start pulse from IDLE -> count=0x01 and tick=1 for one cycle, 4 edges after the start edge. After 40 edges total, count=0x10, with the digit0 9->0 carry observed at 0x09->0x10.
3. Free-run to 0x99 -> on the next increment count=0x00 and wrap=1 for exactly one cycle. tick=1 in the same cycle. running stays 1.
4. stop when count=0x05 and prescaler=2, hold 8 cycles -> count stays 0x05 and tick=0. Then start -> count=0x06 on the 2nd edge after the start edge.
5. target_en=1, target=0x12, start -> at count=0x12: done=1, running=0. Count holds for 20 cycles. A start pulse is ignored. clear -> count=0x00, done=0, IDLE. target=0x1A -> no done through a full wrap.
6. In RUN, assert clear+start together -> IDLE, count=0x00. Assert stop+start together in RUN -> PAUSE.

Source files
------------

// File: rtl/decade_pkg.sv
// Shared types and constants for the decade run controller and its digit cells.
package decade_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} run_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Successor of a BCD digit; anything at or above 9 rolls to 0 so a digit never leaves 0-9.
  function automatic bcd_t bcd_succ(input bcd_t d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/decade_cell.sv
// One BCD digit of the cascade: clears, optionally loads, and increments with carry out at 9.
module decade_cell
  import decade_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic load_en,
  input  bcd_t load_val,
  output bcd_t q,
  output bcd_t nxt,
  output logic carry_out
);

  bcd_t q_q, q_d;

  assign q         = q_q;
  assign nxt       = inc ? bcd_succ(q_q) : q_q;
  assign carry_out = inc & (q_q == BCD_MAX);

  // Out-of-range load values are refused so the digit stays a legal BCD value.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load_en && (load_val <= BCD_MAX)) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = bcd_succ(q_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/decade_run_ctrl.sv
// Run/stop sequencer for a cascade of decade counters: prescaled count ticks,
// start/stop/clear command FSM, ripple through DIGITS cells and terminal-count halt.
module decade_run_ctrl
  import decade_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                target_en,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                tick,
  output logic                wrap
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

  run_state_t state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic done_q, done_d;
  logic tick_q, tick_d;
  logic wrap_q, wrap_d;

  logic cnt_clr;
  logic cnt_inc;
  logic [DIGITS-1:0] dig_inc;
  logic [DIGITS-1:0] carry;
  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_nxt;
  logic wrap_hit;
  logic target_hit;

  // An increment happens on a RUN edge that completes a prescaler period and is not pre-empted by a command.
  assign cnt_inc = (state_q == RUN) && !clear && !stop && (pre_q == PRE_LAST);

  // Each digit's increment is decoded from the registered count below it, so there is no combinational carry chain.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign dig_inc[g] = cnt_inc;
    end else begin : g_upper
      assign dig_inc[g] = cnt_inc && (count_q[4*g-1:0] == ALL_NINES[4*g-1:0]);
    end

    decade_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .clr       (cnt_clr),
      .inc       (dig_inc[g]),
      .load_en   (1'b0),
      .load_val  (4'd0),
      .q         (count_q[4*g +: 4]),
      .nxt       (count_nxt[4*g +: 4]),
      .carry_out (carry[g])
    );
  end

  assign wrap_hit   = &carry;
  assign target_hit = target_en && (count_nxt == target);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_clr = 1'b0;
    if (clear) begin
      state_d = IDLE;
      pre_d   = '0;
      done_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (start && !stop) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (cnt_inc) begin
            pre_d  = '0;
            tick_d = 1'b1;
            wrap_d = wrap_hit;
            if (target_hit) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == RUN);
  assign done    = done_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule
